// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, settle length and
// one-hot to binary conversion.
package uart_arb_pkg;

  localparam int SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SETTLE = 2'd2
  } arb_state_t;

  function automatic logic [2:0] onehot_to_bin(input logic [7:0] oh);
    logic [2:0] b;
    b = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[3'(i)]) b = b | 3'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and TX-FIFO side signals of the UART TX arbiter, bundled for
// connection between the arbiter (slave) and its environment (master).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic                 tx_full_i;
  logic                 tx_wr_o;
  logic [7:0]           tx_wdata_o;
  logic [NUM_REQ-1:0]   grant_o;
  logic [2:0]           grant_id_o;
  logic                 busy_o;

  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_full_i,
    input  req_ready_o, tx_wr_o, tx_wdata_o, grant_o, grant_id_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_full_i,
    output req_ready_o, tx_wr_o, tx_wdata_o, grant_o, grant_id_o, busy_o
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after the
// pointer, wrapping, as one-hot and binary index.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IW-1:0]      idx_o
);

  logic        found;
  int unsigned k;

  always_comb begin
    onehot_o = '0;
    found    = 1'b0;
    k        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(ptr_i) + i) % 32'(NUM_REQ);
      if (!found && valid_i[IW'(k)]) begin
        onehot_o[IW'(k)] = 1'b1;
        found            = 1'b1;
      end
    end
  end

  assign idx_o = IW'(onehot_to_bin(8'(onehot_o)));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX FIFO write port
// among NUM_REQ byte-stream requesters.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 1024
) (
  input logic               clk_i,
  input logic               rst_i,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  arb_state_t          state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IW-1:0]       owner_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [BW-1:0]       burst_q;
  logic [TW-1:0]       idle_q;
  logic [SW-1:0]       settle_q;
  logic                release_q;
  logic                tx_wr_q;
  logic [7:0]          tx_wdata_q;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IW-1:0]       pick_idx;
  logic [7:0]          req_byte [NUM_REQ];
  logic                own_valid, own_last, xfer;
  logic [BW-1:0]       burst_nxt;
  logic                burst_hit, timeout_hit;
  logic [IW-1:0]       ptr_nxt;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .valid_i  (bus.req_valid_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_byte[g] = bus.req_data_i[8*g +: 8];
  end

  assign own_valid   = bus.req_valid_i[owner_q];
  assign own_last    = bus.req_last_i[owner_q];
  assign xfer        = (state_q == ST_GRANT) && own_valid && !bus.tx_full_i;
  assign burst_nxt   = (&burst_q) ? burst_q : burst_q + 1'b1;
  assign burst_hit   = (MAX_BURST != 0) && (burst_nxt >= BW'(MAX_BURST));
  assign timeout_hit = (IDLE_TIMEOUT != 0) && (idle_q == TW'(IDLE_TIMEOUT - 1));
  assign ptr_nxt     = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Ready depends only on state, grant and FIFO status so requesters never
  // see a combinational loop through their own valid.
  always_comb begin
    bus.req_ready_o = '0;
    if (state_q == ST_GRANT && !bus.tx_full_i) bus.req_ready_o = grant_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      burst_q    <= '0;
      idle_q     <= '0;
      settle_q   <= '0;
      release_q  <= 1'b0;
      tx_wr_q    <= 1'b0;
      tx_wdata_q <= '0;
    end else begin
      tx_wr_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|bus.req_valid_i) begin
            grant_q <= pick_oh;
            owner_q <= pick_idx;
            burst_q <= '0;
            idle_q  <= '0;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (xfer) begin
            tx_wr_q    <= 1'b1;
            tx_wdata_q <= req_byte[owner_q];
            burst_q    <= burst_nxt;
            idle_q     <= '0;
            release_q  <= own_last || burst_hit;
            settle_q   <= '0;
            state_q    <= ST_SETTLE;
          end else if (!own_valid) begin
            if (timeout_hit) begin
              grant_q  <= '0;
              rr_ptr_q <= ptr_nxt;
              state_q  <= ST_IDLE;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            if (release_q) begin
              grant_q  <= '0;
              rr_ptr_q <= ptr_nxt;
              state_q  <= ST_IDLE;
            end else begin
              state_q <= ST_GRANT;
            end
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_wr_o    = tx_wr_q;
  assign bus.tx_wdata_o = tx_wdata_q;
  assign bus.grant_o    = grant_q;
  assign bus.grant_id_o = 3'(owner_q);
  assign bus.busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 requesters, burst limit 4, idle
// timeout 16) with hand-computed byte order, grant order and timing.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .MAX_BURST    (4),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  logic [8:0]  src [N][16];
  int unsigned head [N];
  int unsigned len  [N];

  logic [7:0]  wr_data [32];
  int unsigned wr_cyc  [32];
  int unsigned n_wr;
  logic [2:0]  gnt_log [16];
  int unsigned n_gnt;
  int unsigned cyc;
  int unsigned fall_cyc;
  logic        prev_busy;
  logic [N-1:0] prev_grant;
  logic        any_ready;

  logic [7:0] exp2_wr  [6] = '{8'h11, 8'h12, 8'h13, 8'h10, 8'h21, 8'h20};
  logic [2:0] exp2_gnt [6] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd0};
  logic [7:0] exp4_wr  [11] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hA4,
                                8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
  logic [2:0] exp4_gnt [4] = '{3'd2, 3'd3, 3'd2, 3'd2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (head[k] < len[k]) begin
        bus.req_valid_i[k]        = 1'b1;
        bus.req_data_i[8*k +: 8]  = src[k][head[k]][7:0];
        bus.req_last_i[k]         = src[k][head[k]][8];
      end else begin
        bus.req_valid_i[k]        = 1'b0;
        bus.req_data_i[8*k +: 8]  = 8'h00;
        bus.req_last_i[k]         = 1'b0;
      end
    end
  endtask

  task automatic push(input int k, input logic [7:0] b, input logic last);
    src[k][len[k]] = {last, b};
    len[k]++;
  endtask

  task automatic clear_log();
    n_wr  = 0;
    n_gnt = 0;
    for (int i = 0; i < 32; i++) wr_data[i] = 8'h00;
    for (int i = 0; i < 16; i++) gnt_log[i] = 3'd0;
  endtask

  function automatic bit queues_empty();
    bit e = 1'b1;
    for (int k = 0; k < N; k++) if (head[k] < len[k]) e = 1'b0;
    return e;
  endfunction

  // One clock: sample on the falling edge, advance requesters after the rising edge.
  task automatic step();
    logic [N-1:0] fire;
    @(negedge clk);
    fire      = bus.req_valid_i & bus.req_ready_o;
    any_ready = any_ready | (|bus.req_ready_o);
    if (bus.tx_wr_o && n_wr < 32) begin
      wr_data[n_wr] = bus.tx_wdata_o;
      wr_cyc[n_wr]  = cyc;
      n_wr++;
    end
    if (bus.grant_o != '0 && prev_grant == '0 && n_gnt < 16) begin
      gnt_log[n_gnt] = bus.grant_id_o;
      n_gnt++;
    end
    prev_grant = bus.grant_o;
    @(posedge clk);
    #1;
    cyc++;
    if (prev_busy && !bus.busy_o) fall_cyc = cyc;
    prev_busy = bus.busy_o;
    for (int k = 0; k < N; k++) if (fire[k]) head[k]++;
    drive();
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (queues_empty() && !bus.busy_o) done = 1'b1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      len[k]  = 0;
    end
    rst           = 1'b1;
    bus.tx_full_i = 1'b0;
    drive();
    clear_log();
    cyc = 0; fall_cyc = 0; prev_busy = 1'b0; prev_grant = '0; any_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  32'(bus.req_ready_o), 32'd0);
    check("rst_tx_wr",  32'(bus.tx_wr_o),     32'd0);
    check("rst_wdata",  32'(bus.tx_wdata_o),  32'd0);
    check("rst_grant",  32'(bus.grant_o),     32'd0);
    check("rst_gid",    32'(bus.grant_id_o),  32'd0);
    check("rst_busy",   32'(bus.busy_o),      32'd0);
    rst = 1'b0;

    // Single requester, three-byte message.
    clear_log();
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    drive();
    run_until_idle(100, "t1_done");
    check("t1_nwr", n_wr, 3);
    check("t1_b0", 32'(wr_data[0]), 32'h41);
    check("t1_b1", 32'(wr_data[1]), 32'h42);
    check("t1_b2", 32'(wr_data[2]), 32'h43);
    check("t1_gap0", wr_cyc[1] - wr_cyc[0], 3);
    check("t1_gap1", wr_cyc[2] - wr_cyc[1], 3);
    check("t1_ngnt", n_gnt, 1);
    check("t1_gid", 32'(gnt_log[0]), 32'd0);
    check("t1_grant_idle", 32'(bus.grant_o), 32'd0);

    // All requesters valid; pointer is 1 after the previous release.
    clear_log();
    push(0, 8'h10, 1'b1); push(0, 8'h20, 1'b1);
    push(1, 8'h11, 1'b1); push(1, 8'h21, 1'b1);
    push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
    drive();
    run_until_idle(200, "t2_done");
    check("t2_nwr", n_wr, 6);
    check("t2_ngnt", n_gnt, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_wr%0d", i), 32'(wr_data[i]), 32'(exp2_wr[i]));
      check($sformatf("t2_gnt%0d", i), 32'(gnt_log[i]), 32'(exp2_gnt[i]));
    end

    // FIFO full held for 20 cycles while granted.
    clear_log();
    bus.tx_full_i = 1'b1;
    push(2, 8'h55, 1'b1);
    drive();
    step();
    check("t3_grant", 32'(bus.grant_o), 32'h4);
    check("t3_gid", 32'(bus.grant_id_o), 32'd2);
    any_ready = 1'b0;
    repeat (20) step();
    check("t3_ready_low", 32'(any_ready), 32'd0);
    check("t3_no_wr", n_wr, 0);
    check("t3_busy_held", 32'(bus.busy_o), 32'd1);
    check("t3_grant_held", 32'(bus.grant_o), 32'h4);
    bus.tx_full_i = 1'b0;
    run_until_idle(50, "t3_done");
    check("t3_nwr", n_wr, 1);
    check("t3_byte", 32'(wr_data[0]), 32'h55);

    // Burst limit: requester 2 streams 10 bytes, requester 3 joins.
    clear_log();
    for (int i = 0; i < 10; i++) push(2, 8'hA0 + 8'(i), 1'b0);
    drive();
    step(); step();
    push(3, 8'hB0, 1'b1);
    drive();
    run_until_idle(300, "t4_done");
    check("t4_nwr", n_wr, 11);
    check("t4_ngnt", n_gnt, 4);
    for (int i = 0; i < 11; i++)
      check($sformatf("t4_wr%0d", i), 32'(wr_data[i]), 32'(exp4_wr[i]));
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_gnt%0d", i), 32'(gnt_log[i]), 32'(exp4_gnt[i]));

    // Idle timeout: owner goes silent after two bytes.
    clear_log();
    push(1, 8'hC1, 1'b0); push(1, 8'hC2, 1'b0);
    drive();
    run_until_idle(100, "t5_done");
    check("t5_nwr", n_wr, 2);
    check("t5_gid", 32'(gnt_log[0]), 32'd1);
    check("t5_release", fall_cyc - wr_cyc[1], 18);

    // Reset while settling mid-message.
    clear_log();
    push(3, 8'hD0, 1'b0); push(3, 8'hD1, 1'b0); push(3, 8'hD2, 1'b1);
    drive();
    for (int i = 0; i < 10 && n_wr == 0; i++) step();
    check("t6_first_wr", n_wr, 1);
    check("t6_pre_busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    push(0, 8'hE0, 1'b1);
    drive();
    step();
    check("t6_ready", 32'(bus.req_ready_o), 32'd0);
    check("t6_tx_wr", 32'(bus.tx_wr_o),     32'd0);
    check("t6_wdata", 32'(bus.tx_wdata_o),  32'd0);
    check("t6_grant", 32'(bus.grant_o),     32'd0);
    check("t6_gid",   32'(bus.grant_id_o),  32'd0);
    check("t6_busy",  32'(bus.busy_o),      32'd0);
    step();
    clear_log();
    rst = 1'b0;
    run_until_idle(100, "t6_done");
    check("t6_ngnt", n_gnt, 2);
    check("t6_gnt0", 32'(gnt_log[0]), 32'd0);
    check("t6_gnt1", 32'(gnt_log[1]), 32'd3);
    check("t6_nwr", n_wr, 3);
    check("t6_wr0", 32'(wr_data[0]), 32'hE0);
    check("t6_wr1", 32'(wr_data[1]), 32'hD1);
    check("t6_wr2", 32'(wr_data[2]), 32'hD2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-granular round-robin arbiter that shares the single UART transmit path among several byte-stream requesters (e.g. core console, bootloader, trap reporter). It sits in front of the UART TX top block, drives that block's write-enable/write-data pair, and throttles on its FIFO-full status so no byte is ever dropped. A requester holds the grant until it marks the last byte of a message, hits the burst limit, or goes silent past a timeout.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MAX_BURST, 64, bytes per grant before forced rotation; 0 = unlimited
- IDLE_TIMEOUT, 1024, cycles a granted requester may hold valid low mid-message before release; 0 = never
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester byte valid
- req_data_i  in  8*NUM_REQ  byte for requester k in bits [8k+7:8k]
- req_last_i  in  NUM_REQ  byte is last of message
- req_ready_o  out  NUM_REQ  per-requester accept
- tx_full_i  in  1  TX FIFO full status
- tx_wr_o  out  1  one-cycle write strobe to TX FIFO
- tx_wdata_o  out  8  byte to TX FIFO
- grant_o  out  NUM_REQ  one-hot current owner, 0 when idle
- grant_id_o  out  3  binary owner index, valid when busy_o
- busy_o  out  1  a grant is held

## Operation
- Byte transfer = req_valid_i[k] & req_ready_o[k]; req_ready_o is combinational from state, grant and tx_full_i only (never from req_valid_i).
- States: IDLE, GRANT, SETTLE.
- IDLE: if any req_valid_i, select first requester at or after rr_ptr (wrapping NUM_REQ-1 -> 0); load grant, clear burst and timeout counters -> GRANT. No valid: stay.
- GRANT: req_ready_o[owner] = !tx_full_i; all others 0. On transfer -> SETTLE; set release flag if req_last_i, or MAX_BURST != 0 and burst count reaches MAX_BURST. While owner valid low, timeout counter increments; reaching IDLE_TIMEOUT (non-zero) -> IDLE with rr_ptr = owner+1.
- SETTLE: ready low for exactly SETTLE_CYCLES (2) cycles, covering write-to-full latency of the TX block; then release ? (IDLE, rr_ptr = owner+1 mod NUM_REQ) : GRANT.
- Owner valid high while tx_full_i high: wait in GRANT, timeout counter does not advance.
- Burst counter saturates; width ceil(log2(MAX_BURST+1)).
- req_last_i on a burst-limit byte: single release, no double pointer advance.

## Timing
- Reset values: req_ready_o 0, tx_wr_o 0, tx_wdata_o 0, grant_o 0, grant_id_o 0, busy_o 0, state IDLE, rr_ptr 0.
- Request to first ready: 1 cycle (IDLE registers grant).
- Transfer in cycle t -> tx_wr_o high for one cycle at t+1, tx_wdata_o = accepted byte, held until next write.
- Max throughput: 1 byte / 3 cycles.
- Release to next grant: SETTLE end -> IDLE (1 cycle) -> GRANT.
- busy_o = state != IDLE; grant_o/grant_id_o stable for whole grant.
- Reset mid-message: counters and grant cleared next edge, no tx_wr_o after reset edge; partially sent message is not resumed.

## Structure
- Shared package uart_arb_pkg: state enum, SETTLE_CYCLES = 2, one-hot/binary helper function.
- One sub-module natural: uart_rr_pick (combinational round-robin selector: valid vector + pointer -> one-hot + index).
- Burst and timeout counters stay inline.

## Test plan
- Single requester 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) -> tx_wr_o pulses at 3-cycle spacing with those bytes, grant released, rr_ptr = 1.
- All 4 valid at once, 1-byte messages -> grants in order 0,1,2,3,0; no back-to-back grant to same requester while others wait.
- tx_full_i forced high during GRANT for 20 cycles -> ready low, no tx_wr_o, no timeout release; byte accepted after full drops.
- MAX_BURST=4, requester 2 sends 10 bytes no last, requester 3 waiting -> 4 bytes from 2, then 3 granted, then 2 resumes.
- IDLE_TIMEOUT=16, owner drops valid after 2 bytes -> release after 16 cycles, busy_o low next cycle.
- rst_i asserted in SETTLE mid-message -> all outputs at reset values next edge, first post-reset grant to requester 0.
